// File: rtl/ram_arbiter.sv
// Two-master arbiter sharing one single-cycle data RAM port (master 0 = CPU, master 1 = DMA/loader).
// Define ARB_FIXED_PRIO_EN for fixed m0 priority; default build uses round-robin with a symmetric hold limit.
module ram_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_HOLD = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [3:0]        m0_sel,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_ack,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [3:0]        m1_sel,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_ack,
    output logic              ram_ce,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [3:0]        ram_sel,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [1:0]        owner
);

    localparam int HOLD_W = $clog2(MAX_HOLD) + 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic [HOLD_W-1:0] HOLD_ZERO = {HOLD_W{1'b0}};

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_t;

    state_t             state_r, next_state_s;
    logic               last_owner_r, next_last_owner_s;
    logic [HOLD_W-1:0]  hold_cnt_r, next_hold_cnt_s;

    function automatic logic [HOLD_W-1:0] hold_inc(input logic [HOLD_W-1:0] v);
        if (v == {HOLD_W{1'b1}}) begin
            return v;
        end else begin
            return v + HOLD_W'(1);
        end
    endfunction

    // Next-state, tie-break and hold-limit logic
    always_comb begin
        next_state_s      = state_r;
        next_last_owner_s = last_owner_r;
        next_hold_cnt_s   = hold_cnt_r;
        case (state_r)
            IDLE: begin
                next_hold_cnt_s = HOLD_ZERO;
                if (m0_req && m1_req) begin
`ifdef ARB_FIXED_PRIO_EN
                    next_state_s      = OWN0;
                    next_last_owner_s = 1'b0;
`else
                    next_state_s      = last_owner_r ? OWN0 : OWN1;
                    next_last_owner_s = ~last_owner_r;
`endif
                end else if (m0_req) begin
                    next_state_s      = OWN0;
                    next_last_owner_s = 1'b0;
                end else if (m1_req) begin
                    next_state_s      = OWN1;
                    next_last_owner_s = 1'b1;
                end else begin
                    next_state_s = IDLE;
                end
            end
            OWN0: begin
                if (m0_req) begin
`ifdef ARB_FIXED_PRIO_EN
                    next_state_s    = OWN0;
                    next_hold_cnt_s = HOLD_ZERO;
`else
                    if (m1_req && (hold_cnt_r == HOLD_LAST)) begin
                        next_state_s      = OWN1;
                        next_last_owner_s = 1'b1;
                        next_hold_cnt_s   = HOLD_ZERO;
                    end else if (m1_req) begin
                        next_state_s    = OWN0;
                        next_hold_cnt_s = hold_inc(hold_cnt_r);
                    end else begin
                        next_state_s    = OWN0;
                        next_hold_cnt_s = HOLD_ZERO;
                    end
`endif
                end else if (m1_req) begin
                    next_state_s      = OWN1;
                    next_last_owner_s = 1'b1;
                    next_hold_cnt_s   = HOLD_ZERO;
                end else begin
                    next_state_s    = IDLE;
                    next_hold_cnt_s = HOLD_ZERO;
                end
            end
            OWN1: begin
                if (m1_req) begin
                    if (m0_req && (hold_cnt_r == HOLD_LAST)) begin
                        next_state_s      = OWN0;
                        next_last_owner_s = 1'b0;
                        next_hold_cnt_s   = HOLD_ZERO;
                    end else if (m0_req) begin
                        next_state_s    = OWN1;
                        next_hold_cnt_s = hold_inc(hold_cnt_r);
                    end else begin
                        next_state_s    = OWN1;
                        next_hold_cnt_s = HOLD_ZERO;
                    end
                end else if (m0_req) begin
                    next_state_s      = OWN0;
                    next_last_owner_s = 1'b0;
                    next_hold_cnt_s   = HOLD_ZERO;
                end else begin
                    next_state_s    = IDLE;
                    next_hold_cnt_s = HOLD_ZERO;
                end
            end
            default: begin
                next_state_s    = IDLE;
                next_hold_cnt_s = HOLD_ZERO;
            end
        endcase
    end

    // State, last-owner and hold-counter registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r      <= IDLE;
            last_owner_r <= 1'b1;
            hold_cnt_r   <= HOLD_ZERO;
        end else begin
            state_r      <= next_state_s;
            last_owner_r <= next_last_owner_s;
            hold_cnt_r   <= next_hold_cnt_s;
        end
    end

    // Port steering; strobes are masked by rst so an ack-cycle write never commits at a reset edge
    always_comb begin
        ram_ce    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = {ADDR_W{1'b0}};
        ram_sel   = 4'b0000;
        ram_wdata = {DATA_W{1'b0}};
        m0_ack    = 1'b0;
        m1_ack    = 1'b0;
        m0_rdata  = {DATA_W{1'b0}};
        m1_rdata  = {DATA_W{1'b0}};
        owner     = 2'b00;
        case (state_r)
            OWN0: begin
                owner     = 2'b01;
                ram_ce    = m0_req & rst;
                ram_we    = m0_we & m0_req & rst;
                ram_addr  = m0_addr;
                ram_sel   = m0_sel;
                ram_wdata = m0_wdata;
                m0_ack    = m0_req & rst;
                m0_rdata  = ram_rdata;
            end
            OWN1: begin
                owner     = 2'b10;
                ram_ce    = m1_req & rst;
                ram_we    = m1_we & m1_req & rst;
                ram_addr  = m1_addr;
                ram_sel   = m1_sel;
                ram_wdata = m1_wdata;
                m1_ack    = m1_req & rst;
                m1_rdata  = ram_rdata;
            end
            IDLE: begin
                owner = 2'b00;
            end
            default: begin
                owner = 2'b00;
            end
        endcase
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter with a small byte-selectable RAM model.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_sel, m1_sel;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_ack, m1_ack;
    logic        ram_ce, ram_we;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;
    logic [3:0]  ram_sel;
    logic [1:0]  owner;

    logic [31:0] mem [0:63];
    logic        preload;
    int          n_total = 0;
    int          n_bad = 0;
    int          cnt0;
    logic        got1, idle_seen;

    ram_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_HOLD(8)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_sel(m0_sel),
        .m0_wdata(m0_wdata), .m0_rdata(m0_rdata), .m0_ack(m0_ack),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_sel(m1_sel),
        .m1_wdata(m1_wdata), .m1_rdata(m1_rdata), .m1_ack(m1_ack),
        .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr), .ram_sel(ram_sel),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .owner(owner)
    );

    always #5 clk = ~clk;

    assign ram_rdata = mem[ram_addr[7:2]];

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
            mem[8] <= 32'hA5A5_A5A5;
        end else if (ram_ce && ram_we) begin
            for (int b = 0; b < 4; b++)
                if (ram_sel[b]) mem[ram_addr[7:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        preload = 1'b1;
        rst = 1'b0;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10; m0_sel = 4'hF; m0_wdata = 32'h0;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h20; m1_sel = 4'hF; m1_wdata = 32'h0;

        // reset with both requesting
        for (int i = 0; i < 2; i++) begin
            tick();
            #2;
            check("rst_owner", owner, 2'b00);
            check("rst_m0_ack", m0_ack, 1'b0);
            check("rst_m1_ack", m1_ack, 1'b0);
            check("rst_ram_ce", ram_ce, 1'b0);
            check("rst_ram_we", ram_we, 1'b0);
        end
        preload = 1'b0;
        rst = 1'b1;
        #2;
        check("rel_owner_idle", owner, 2'b00);
        tick();
        #2;
        check("tie1_owner", owner, 2'b01);
        check("tie1_m0_ack", m0_ack, 1'b1);
        check("tie1_m1_ack", m1_ack, 1'b0);
        m0_req = 1'b0; m1_req = 1'b0;
        tick();
        tick();
        check("back_idle", owner, 2'b00);

        // second tie: round-robin gives m1 (fixed priority gives m0)
        m0_req = 1'b1; m1_req = 1'b1;
        tick();
        #2;
`ifdef ARB_FIXED_PRIO_EN
        check("tie2_owner", owner, 2'b01);
        check("tie2_m0_ack", m0_ack, 1'b1);
`else
        check("tie2_owner", owner, 2'b10);
        check("tie2_m1_ack", m1_ack, 1'b1);
        check("tie2_m0_ack", m0_ack, 1'b0);
`endif
        m0_req = 1'b0; m1_req = 1'b0;
        tick();
        tick();

        // single master write then read
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h10; m0_sel = 4'hF; m0_wdata = 32'hDEAD_BEEF;
        #2;
        check("wr_first_noack", m0_ack, 1'b0);
        tick();
        #2;
        check("wr_ack", m0_ack, 1'b1);
        check("wr_ram_we", ram_we, 1'b1);
        check("wr_ram_addr", ram_addr, 32'h10);
        check("wr_m1_ack", m1_ack, 1'b0);
        tick();
        m0_we = 1'b0;
        #2;
        check("rd_ack", m0_ack, 1'b1);
        check("rd_data", m0_rdata, 32'hDEAD_BEEF);
        check("rd_m1_ack", m1_ack, 1'b0);
        check("rd_m1_rdata", m1_rdata, 32'h0);
        m0_req = 1'b0;
        tick();
        tick();

        // handover: m1 drops as m0 raises
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h20;
        tick();
        #2;
        check("ho_m1_owner", owner, 2'b10);
        check("ho_m1_rdata", m1_rdata, 32'hA5A5_A5A5);
        tick();
        m1_req = 1'b0; m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10;
        #2;
        check("ho_still_m1", owner, 2'b10);
        check("ho_m0_wait", m0_ack, 1'b0);
        tick();
        #2;
        check("ho_owner_m0", owner, 2'b01);
        check("ho_m0_ack", m0_ack, 1'b1);
        check("ho_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
        m0_req = 1'b0;
        tick();
        tick();

        // starvation bound
        m0_req = 1'b1;
        tick();
        m1_req = 1'b1;
        cnt0 = 0; got1 = 1'b0; idle_seen = 1'b0;
        for (int i = 0; i < 20 && !got1; i++) begin
            #2;
            if (owner == 2'b00) idle_seen = 1'b1;
            if (m1_ack) begin
                got1 = 1'b1;
            end else begin
                if (m0_ack) cnt0++;
                tick();
            end
        end
        check("starve_no_idle", idle_seen, 1'b0);
`ifdef ARB_FIXED_PRIO_EN
        check("starve_m1_blocked", got1, 1'b0);
        check("starve_m0_acks", cnt0, 20);
        m0_req = 1'b0;
        #2;
        check("fp_drop_owner", owner, 2'b01);
        tick();
        #2;
        check("fp_m1_owner", owner, 2'b10);
        check("fp_m1_ack", m1_ack, 1'b1);
`else
        check("starve_m1_granted", got1, 1'b1);
        check("starve_m0_acks", cnt0, 8);
        check("starve_owner", owner, 2'b10);
`endif
        m0_req = 1'b0; m1_req = 1'b0;
        tick();
        tick();

        // reset during m1 write ack cycle
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h20; m1_sel = 4'hF; m1_wdata = 32'h1234_5678;
        tick();
        #2;
        check("rw_m1_ack", m1_ack, 1'b1);
        rst = 1'b0;
        #1;
        check("rw_ram_we_masked", ram_we, 1'b0);
        tick();
        #2;
        check("rw_owner", owner, 2'b00);
        check("rw_mem_kept", mem[8], 32'hA5A5_A5A5);
        rst = 1'b1; m1_req = 1'b0; m1_we = 1'b0;
        tick();
        #2;
        check("rw_idle", owner, 2'b00);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single data_ram port between two masters, one access per cycle.
- Master 0 is the CPU data port; the CPU stalls while its request is un-acked.
- Master 1 is a secondary requester, e.g. a DMA or program loader.
- Registered-owner state machine with round-robin tie-break and a hold limit that bounds starvation; the RAM-side outputs connect directly to data_ram.

Parameters:
- ADDR_W, 32, address width of masters and RAM.
- DATA_W, 32, data width.
- MAX_HOLD, 8, max consecutive ack cycles an owner keeps the grant while the other master requests (>=1).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-low reset
- m0_req  in  1  master 0 access request
- m0_we  in  1  master 0 write enable
- m0_addr  in  ADDR_W  master 0 address
- m0_sel  in  4  master 0 byte select
- m0_wdata  in  DATA_W  master 0 write data
- m0_rdata  out  DATA_W  master 0 read data
- m0_ack  out  1  master 0 access completes this cycle
- m1_req, m1_we, m1_addr, m1_sel, m1_wdata, m1_rdata, m1_ack  same as m0_*
- ram_ce  out  1  RAM chip enable
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_W  RAM address
- ram_sel  out  4  RAM byte select
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data (combinational read)
- owner  out  2  00 idle, 01 m0, 10 m1

Behaviour:
- States: IDLE, OWN0, OWN1. Registers: state, last_owner (1 bit), hold_cnt (saturating, clog2(MAX_HOLD)+1 bits).
- Reset (rst==0 at edge): state=IDLE, last_owner=1 (m0 wins first tie), hold_cnt=0. Consequently all outputs are 0, owner=00.
- Outputs are combinational from state:
  - OWNx: ram_ce=mx_req; ram_we=mx_we&mx_req; ram_addr/sel/wdata=mx_*; mx_ack=mx_req; mx_rdata=ram_rdata.
  - Non-owner: ack=0, rdata=0.
  - IDLE: all ram_* = 0.
- Access rules:
  - A read completes in the ack cycle.
  - A write commits at the rising edge that ends the ack cycle.
  - A master holds req and its fields stable until ack.
  - Holding req high gives back-to-back accesses, one per cycle; addr may change each acked cycle.
- Transitions:
  - IDLE: only m0_req -> OWN0; only m1_req -> OWN1; both -> the master != last_owner; none -> IDLE. First ack comes 1 cycle after req is seen in IDLE.
  - OWNx, mx_req=1: if the other req=1 and hold_cnt==MAX_HOLD-1 -> OWN(other); else stay and hold_cnt++ only when the other req=1 (otherwise hold_cnt=0).
  - OWNx, mx_req=0: other req=1 -> OWN(other) directly, no IDLE bubble; else -> IDLE.
- On every entry to OWNx: last_owner=x, hold_cnt=0.
- Simultaneous deassert by owner and assert by other: handover on the next edge; the other's first ack comes in the following cycle.
- Reset mid-access: an ack-cycle write not yet clocked is dropped if rst is low at that edge (RAM sees ram_we=0 after reset); masters re-request.
- No combinational path from ram_rdata to any control output.

Optional Feature:
- ARB_FIXED_PRIO_EN
- Defined:
  - IDLE ties always go to m0; last_owner is ignored.
  - MAX_HOLD applies only to m1. m0 keeps the grant as long as m0_req=1.
  - m1 is preempted after MAX_HOLD ack cycles while m0 requests.
- Undefined: round-robin tie-break and a symmetric hold limit, as above.

Test Plan:
- Reset: rst=0 for 2 cycles with both req=1 -> all outputs 0, owner=00; release -> owner=01 one cycle later and m0_ack=1.
- Single master: m0 writes 0xDEADBEEF to addr 0x10 (sel=1111), then reads 0x10 -> m0_rdata=0xDEADBEEF in the read ack cycle; m1_ack stays 0 throughout.
- Tie in IDLE after reset: both req in the same cycle -> m0 granted first. Second tie after IDLE with last_owner=0 -> m1 granted (round-robin).
- Starvation bound: m0_req held high, m1_req raised -> m0 gets exactly MAX_HOLD=8 acks, then owner=10 with no idle cycle. With ARB_FIXED_PRIO_EN, m1 waits until m0_req drops.
- Handover: m1 owns, drops req in the same cycle m0 raises req -> owner=01 next cycle, no IDLE state visited.
- Reset mid-write: rst=0 at the edge ending an m1 write ack cycle to addr 0x20 -> RAM location 0x20 unchanged; owner=00 after the edge.
